// File: rtl/regfile_wb_if.sv
// Register file bus: writeback-stage write port plus the two decode-stage
// read ports. The pipeline side drives the master modport and the register
// file sits on the slave modport.
interface regfile_wb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_wb.sv
// 32 x 64-bit architectural register file with a hardwired-zero register.
// The write port is enabled through a binary tree of 1-to-2 enable decoders
// that yields a one-hot write-enable vector. The two read ports are
// combinational and bypass same-cycle write data, so the pipeline needs no
// separate WB->ID forwarding path.
module regfile_wb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  regfile_wb_if.slave   bus
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam int                NUM_NODES = 2 * NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);

  // Decoder tree stored heap-style: node 0 is the root enable (RegWrite).
  // Node n splits into 2n+1 (address bit 0) and 2n+2 (address bit 1).
  // Taking address bits MSB-first, leaf NUM_REGS-1+k is register k.
  logic [NUM_NODES-1:0] dec_tree_s;
  logic [NUM_REGS-1:0]  wr_en_s;

  assign dec_tree_s[0] = bus.RegWrite;

  for (genvar lvl = 0; lvl < ADDR_W; lvl++) begin : g_level
    for (genvar k = 0; k < 2 ** lvl; k++) begin : g_node
      localparam int NODE = (2 ** lvl) - 1 + k;
      // A gated-off parent keeps both children low, even with X address bits.
      assign dec_tree_s[2*NODE+1] = dec_tree_s[NODE] & ~bus.WriteRegister[ADDR_W-1-lvl];
      assign dec_tree_s[2*NODE+2] = dec_tree_s[NODE] &  bus.WriteRegister[ADDR_W-1-lvl];
    end
  end

  assign wr_en_s = dec_tree_s[NUM_NODES-1 -: NUM_REGS];

  // Register storage. The ZERO_REG slot is never loaded, so it stays at its
  // reset value and synthesis reduces it to a constant.
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next-state for each register: load WriteData on its enable, else hold.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en_s[i] && (i != ZERO_REG)) begin
        regs_d[i] = bus.WriteData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // State update; a synchronous reset takes priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read one port: zero register, then same-cycle write bypass, then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (raddr == ZERO_IDX) begin
      val = {DATA_W{1'b0}};
    end else if (we && (waddr == raddr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Both read ports are combinational functions of state and inputs.
  always_comb begin
    bus.ReadData1 = read_port(bus.ReadRegister1, bus.RegWrite, bus.WriteRegister,
                              bus.WriteData, regs_q[bus.ReadRegister1]);
    bus.ReadData2 = read_port(bus.ReadRegister2, bus.RegWrite, bus.WriteRegister,
                              bus.WriteData, regs_q[bus.ReadRegister2]);
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus a randomized
// run, all checked against an array model of the architectural registers.
module tb_regfile_wb;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int XZR    = 31;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(XZR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model of the 32 architectural registers.
  logic [DATA_W-1:0] mdl [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural value seen on a read port for the current inputs.
  function automatic logic [DATA_W-1:0] exp_read(input int ra);
    if (ra == XZR) return 64'h0;
    if (bus.RegWrite === 1'b1 && int'(bus.WriteRegister) == ra) return bus.WriteData;
    return mdl[ra];
  endfunction

  // Advance one clock edge, applying the architectural update to the model.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    end else if (bus.RegWrite === 1'b1 && int'(bus.WriteRegister) != XZR) begin
      mdl[bus.WriteRegister] = bus.WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 64'h0;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      checks++;
      if (bus.ReadData1 !== 64'h0 || bus.ReadData2 !== 64'h0) begin
        $display("FAIL reset_clear idx=%0d rd1=%h rd2=%h required 0", i, bus.ReadData1, bus.ReadData2);
        errors++;
      end
    end
    // Write X5, then reset must wipe it.
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 64'h1111;
    tick();
    bus.RegWrite = 1'b0; bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd5;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h1111) begin
      $display("FAIL reset_prewrite rd1=%h required %h", bus.ReadData1, 64'h1111);
      errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h0 || bus.ReadData2 !== 64'h0) begin
      $display("FAIL reset_x5 rd1=%h rd2=%h required 0", bus.ReadData1, bus.ReadData2);
      errors++;
    end
  endtask

  task automatic test_basic();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd3; bus.WriteData = 64'hDEADBEEF_CAFEF00D;
    tick();
    bus.RegWrite = 1'b0; bus.ReadRegister1 = 5'd3; bus.ReadRegister2 = 5'd4;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'hDEADBEEF_CAFEF00D) begin
      $display("FAIL basic_x3 got %h required %h", bus.ReadData1, 64'hDEADBEEF_CAFEF00D);
      errors++;
    end
    checks++;
    if (bus.ReadData2 !== 64'h0) begin
      $display("FAIL basic_x4 got %h required 0", bus.ReadData2);
      errors++;
    end
  endtask

  task automatic test_write_all();
    for (int i = 0; i < 31; i++) begin
      bus.RegWrite = 1'b1; bus.WriteRegister = 5'(i);
      bus.WriteData = 64'(i) * 64'h0101010101010101;
      tick();
    end
    bus.RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [DATA_W-1:0] want;
      want = (i == XZR) ? 64'h0 : 64'(i) * 64'h0101010101010101;
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(i);
      #1;
      checks++;
      if (bus.ReadData1 !== want || bus.ReadData2 !== want) begin
        $display("FAIL write_all idx=%0d rd1=%h rd2=%h required %h", i, bus.ReadData1, bus.ReadData2, want);
        errors++;
      end
    end
  endtask

  task automatic test_xzr();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd31; bus.WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.ReadRegister1 = 5'd31; bus.ReadRegister2 = 5'd31;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h0 || bus.ReadData2 !== 64'h0) begin
      $display("FAIL xzr_same_cycle rd1=%h rd2=%h required 0", bus.ReadData1, bus.ReadData2);
      errors++;
    end
    tick();
    bus.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h0 || bus.ReadData2 !== 64'h0) begin
      $display("FAIL xzr_next_cycle rd1=%h rd2=%h required 0", bus.ReadData1, bus.ReadData2);
      errors++;
    end
    for (int i = 0; i < 31; i++) begin
      bus.ReadRegister1 = 5'(i);
      #1;
      checks++;
      if (bus.ReadData1 !== mdl[i]) begin
        $display("FAIL xzr_others idx=%0d got %h required %h", i, bus.ReadData1, mdl[i]);
        errors++;
      end
    end
  endtask

  task automatic test_bypass();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd7; bus.WriteData = 64'h10;
    tick();
    bus.WriteData = 64'h20; bus.ReadRegister1 = 5'd7; bus.ReadRegister2 = 5'd7;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h20 || bus.ReadData2 !== 64'h20) begin
      $display("FAIL bypass_before rd1=%h rd2=%h required 20", bus.ReadData1, bus.ReadData2);
      errors++;
    end
    tick();
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h20 || bus.ReadData2 !== 64'h20) begin
      $display("FAIL bypass_after rd1=%h rd2=%h required 20", bus.ReadData1, bus.ReadData2);
      errors++;
    end
    // Restore 0x10, then drop RegWrite with 0x20 still on WriteData.
    bus.WriteData = 64'h10;
    tick();
    bus.RegWrite = 1'b0; bus.WriteData = 64'h20;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h10 || bus.ReadData2 !== 64'h10) begin
      $display("FAIL bypass_disabled rd1=%h rd2=%h required 10", bus.ReadData1, bus.ReadData2);
      errors++;
    end
  endtask

  task automatic test_collision();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 64'hABCD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.RegWrite = 1'b0; bus.ReadRegister1 = 5'd9; bus.ReadRegister2 = 5'd7;
    #1;
    checks++;
    if (bus.ReadData1 !== 64'h0 || bus.ReadData2 !== 64'h0) begin
      $display("FAIL reset_collision rd1=%h rd2=%h required 0", bus.ReadData1, bus.ReadData2);
      errors++;
    end
  endtask

  task automatic test_x_addr();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd12; bus.WriteData = 64'h1234_5678_9ABC_DEF0;
    tick();
    bus.RegWrite = 1'b0; bus.WriteRegister = 5'bxxxxx; bus.WriteData = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    tick();
    bus.WriteRegister = 5'd0;
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister2 = 5'(i);
      #1;
      checks++;
      if (bus.ReadData2 !== exp_read(i)) begin
        $display("FAIL x_addr idx=%0d got %h required %h", i, bus.ReadData2, exp_read(i));
        errors++;
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset             = ($urandom_range(31, 0) == 0);
      bus.RegWrite      = 1'($urandom_range(1, 0));
      bus.WriteRegister = 5'($urandom_range(31, 0));
      bus.WriteData     = {$urandom, $urandom};
      bus.ReadRegister1 = ($urandom_range(3, 0) == 0) ? bus.WriteRegister : 5'($urandom_range(31, 0));
      bus.ReadRegister2 = ($urandom_range(3, 0) == 0) ? bus.ReadRegister1 : 5'($urandom_range(31, 0));
      #1;
      checks++;
      if (bus.ReadData1 !== exp_read(int'(bus.ReadRegister1))) begin
        $display("FAIL random_rd1 n=%0d idx=%0d got %h required %h", n, bus.ReadRegister1,
                 bus.ReadData1, exp_read(int'(bus.ReadRegister1)));
        errors++;
      end
      checks++;
      if (bus.ReadData2 !== exp_read(int'(bus.ReadRegister2))) begin
        $display("FAIL random_rd2 n=%0d idx=%0d got %h required %h", n, bus.ReadRegister2,
                 bus.ReadData2, exp_read(int'(bus.ReadRegister2)));
        errors++;
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_write_all();
    test_xzr();
    test_bypass();
    test_collision();
    test_x_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
